// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with its controller FSM.
// Serial one-word-per-ack write-back and refill bursts to main memory.
module dcache_wb_ctrl #(
  parameter int WORD_SIZE_BITS    = 32,
  parameter int BLOCK_OFFSET_BITS = 2,
  parameter int INDEX_BITS        = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_valid,
  input  logic                      cpu_req_we,
  input  logic [WORD_SIZE_BITS-1:0] cpu_req_addr,
  input  logic [WORD_SIZE_BITS-1:0] cpu_req_wdata,
  output logic                      cpu_req_ready,
  output logic                      cpu_resp_valid,
  output logic [WORD_SIZE_BITS-1:0] cpu_resp_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [WORD_SIZE_BITS-1:0] mem_addr,
  output logic [WORD_SIZE_BITS-1:0] mem_wdata,
  input  logic                      mem_ack,
  input  logic [WORD_SIZE_BITS-1:0] mem_rdata
);

  localparam int TAG_BITS = WORD_SIZE_BITS - INDEX_BITS - BLOCK_OFFSET_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << BLOCK_OFFSET_BITS;
  localparam int IDX_LO   = BLOCK_OFFSET_BITS + 2;
  localparam int TAG_LO   = IDX_LO + INDEX_BITS;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, REFILL} state_t;

  state_t                       state_q, state_d;
  logic [BLOCK_OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic                         req_we_q;
  logic [WORD_SIZE_BITS-1:0]    req_addr_q, req_wdata_q;
  logic [LINES-1:0]             valid_q, dirty_q;
  logic [TAG_BITS-1:0]          tag_q  [LINES];
  logic [WORD_SIZE_BITS-1:0]    data_q [LINES][WORDS];

  logic [TAG_BITS-1:0]          req_tag;
  logic [INDEX_BITS-1:0]        req_idx;
  logic [BLOCK_OFFSET_BITS-1:0] req_off;
  logic                         hit, store_hit, fill_wr, fill_done, wb_done;
  logic                         unused_addr_bits;

  assign req_tag          = req_addr_q[WORD_SIZE_BITS-1:TAG_LO];
  assign req_idx          = req_addr_q[TAG_LO-1:IDX_LO];
  assign req_off          = req_addr_q[IDX_LO-1:2];
  assign hit              = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_addr_bits = ^req_addr_q[1:0];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    store_hit      = 1'b0;
    fill_wr        = 1'b0;
    fill_done      = 1'b0;
    wb_done        = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        cnt_d = '0;
        if (hit) begin
          cpu_resp_valid = 1'b1;
          if (req_we_q) store_hit = 1'b1;
          else          cpu_resp_rdata = data_q[req_idx][req_off];
          state_d = IDLE;
        end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
          state_d = WB;
        end else begin
          state_d = REFILL;
        end
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[req_idx], req_idx, cnt_q, 2'b00};
        mem_wdata = data_q[req_idx][cnt_q];
        if (mem_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            wb_done = 1'b1;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, cnt_q, 2'b00};
        if (mem_ack) begin
          fill_wr = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          // Re-enter LOOKUP so the now-resident line serves the request as a hit.
          if (cnt_q == '1) begin
            fill_done = 1'b1;
            state_d   = LOOKUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && cpu_req_valid) begin
        req_we_q    <= cpu_req_we;
        req_addr_q  <= cpu_req_addr;
        req_wdata_q <= cpu_req_wdata;
      end
      if (store_hit) dirty_q[req_idx] <= 1'b1;
      if (wb_done)   dirty_q[req_idx] <= 1'b0;
      if (fill_done) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; validity alone decides residency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (store_hit) data_q[req_idx][req_off] <= req_wdata_q;
      if (fill_wr)   data_q[req_idx][cnt_q]   <= mem_rdata;
      if (fill_done) tag_q[req_idx]           <= req_tag;
    end
  end

endmodule

// File: doc/dcache_wb_ctrl.md
Name: dcache_wb_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache with its own controller FSM.
- Sits between the multi-cycle core's load/store unit and main memory.
- Parametrised in word width, words per line and line count.
- Adds per-line valid bits, multi-word lines, a CPU request/response handshake, and serial dirty-line write-back and refill bursts to memory.

Parameters:
- WORD_SIZE_BITS, 32: data/address width.
- BLOCK_OFFSET_BITS, 2: log2 of words per line; 4 words per line by default.
- INDEX_BITS, 6: log2 of line count; 64 lines by default.
- Derived: TAG_BITS = WORD_SIZE_BITS - INDEX_BITS - BLOCK_OFFSET_BITS - 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- cpu_req_valid  in  1  CPU access request.
- cpu_req_we  in  1  1=store, 0=load.
- cpu_req_addr  in  WORD_SIZE_BITS  byte address; bits [1:0] ignored.
- cpu_req_wdata  in  WORD_SIZE_BITS  store data (full word).
- cpu_req_ready  out  1  cache can accept a request.
- cpu_resp_valid  out  1  one-cycle completion pulse.
- cpu_resp_rdata  out  WORD_SIZE_BITS  load data, valid with cpu_resp_valid.
- mem_req  out  1  memory word transfer request.
- mem_we  out  1  1=write-back word, 0=refill word.
- mem_addr  out  WORD_SIZE_BITS  word-aligned byte address.
- mem_wdata  out  WORD_SIZE_BITS  write-back data.
- mem_ack  in  1  one word transferred this cycle.
- mem_rdata  in  WORD_SIZE_BITS  refill data, valid with mem_ack.

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active-high.
- Address split: tag = addr[W-1 : W-TAG_BITS]; index = next INDEX_BITS; word offset = addr[BLOCK_OFFSET_BITS+1:2].
- Per-line state: valid, dirty, tag, 2^BLOCK_OFFSET_BITS data words.
- Hit = valid & (tag match).
- Reset state:
  - All valid and dirty bits cleared in one cycle; tag and data arrays not cleared.
  - FSM to IDLE, burst counter to 0.
  - All outputs 0 except cpu_req_ready, which is 1 in the first cycle after reset.
- FSM states: IDLE, LOOKUP, WB, REFILL.
- IDLE:
  - cpu_req_ready=1.
  - On cpu_req_valid, register we/addr/wdata and go to LOOKUP.
  - No other output activity.
- LOOKUP:
  - cpu_req_ready=0; tag compare on the registered request.
  - Hit, load: cpu_resp_rdata = line word; cpu_resp_valid=1 this cycle; go to IDLE.
  - Hit, store: write word, set dirty; cpu_resp_valid=1 (rdata = 0); go to IDLE.
  - Miss with valid & dirty: go to WB, counter=0.
  - Miss otherwise: go to REFILL, counter=0.
- WB:
  - mem_req=1, mem_we=1.
  - mem_addr = {stored tag, index, counter, 2'b00}; mem_wdata = line word[counter].
  - On mem_ack, counter+1; after last word, counter=0, clear dirty, go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0.
  - mem_addr = {req tag, index, counter, 2'b00}.
  - On mem_ack, store mem_rdata into word[counter], counter+1.
  - After last word: tag=req tag, valid=1, dirty=0, go to LOOKUP (guaranteed hit).
- Memory handshake:
  - mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ack=0.
  - Each mem_ack cycle moves exactly one word; words are transferred in ascending order from word 0.
  - mem_req may stay high across consecutive acks and drops in the cycle after the final ack.
  - mem_ack while mem_req=0 is ignored.
- Latency:
  - Request accepted at cycle T.
  - Hit: cpu_resp_valid at T+1; cpu_req_ready again at T+2.
  - Miss: cpu_resp_valid 1 cycle after the final refill ack.
- Throughput: at most one request per 2 cycles.
- cpu_req_valid while cpu_req_ready=0 is ignored; the requester must hold it.
- Boundary cases:
  - Counter wraps to 0 at 2^BLOCK_OFFSET_BITS.
  - Index 0 and index 2^INDEX_BITS-1 behave identically.
  - Same index, different tag: eviction.
- Reset mid-burst:
  - Burst abandoned; mem_req=0 from the next cycle.
  - Dirty data in flight is lost; all lines invalid.
  - No cpu_resp_valid for the aborted request.
- rst dominates cpu_req_valid and mem_ack in the same cycle.

Test Plan:
- Cold load miss: load 0x0000_0104 after reset -> 4 refill reads at 0x100, 0x104, 0x108, 0x10C, mem_ack every cycle with data 0xA0..0xA3 -> cpu_resp_rdata=0xA1 one cycle after last ack; a repeat load is a hit with resp at T+1 and no mem_req.
- Store hit, then conflicting load (default params, index stride 0x400): store 0xDEADBEEF to 0x0000_0108 after refill -> resp at T+1, no mem_req; load 0x0000_0508 -> write-back of 4 words at 0x100..0x10C with word 2=0xDEADBEEF, then refill at 0x500..0x50C, correct rdata.
- Stalled memory: random 0-5 cycle mem_ack gaps during WB and REFILL -> mem_addr/mem_wdata stable while waiting, exactly 4 acks consumed per burst, correct data.
- Reset mid-refill: assert rst after 2 acks -> mem_req=0 next cycle, no response, cpu_req_ready=1; the following load to the same address misses and refills all 4 words.
- Back-to-back hits: held cpu_req_valid over 6 hits -> response every 2 cycles, mem_req never asserted.
- Spurious mem_ack in IDLE: no state change, outputs unchanged.
